stream_downsize_keep: RTL and testbench

STREAM_DOWNSIZE_KEEP -- requirements
Module: stream_downsize_keep

---
 rtl/stream_downsize_keep.sv | 101 ++++++++++
 tb/tb_stream_downsize_keep.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsize_keep.sv
// Wide-to-narrow stream downsizer with per-lane keep mask.
// One wide beat is buffered and emitted lane by lane, skipping unkept lanes.
module stream_downsize_keep #(
  parameter int T_DATA_WIDTH  = 1,
  parameter int T_DATA_RATIO  = 2,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO),
  parameter int T_LANE_ORDER  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  logic [T_DATA_WIDTH-1:0]  r_data [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0]  r_mask;
  logic                     r_last;
  logic                     r_full;

  logic [T_WIDTH_RATIO-1:0] w_idx;
  logic [T_DATA_RATIO-1:0]  w_oh;
  logic                     w_any;
  logic                     w_one;
  logic                     w_final;
  logic                     w_drop;
  logic                     w_pop;
  logic                     w_load;
  logic                     w_done;

  // Scan so the preferred end of the mask is the last write and wins.
  always_comb begin
    w_idx = '0;
    w_oh  = '0;
    if (T_LANE_ORDER == 0) begin
      for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
        if (r_mask[i]) begin
          w_idx    = T_WIDTH_RATIO'(i);
          w_oh     = '0;
          w_oh[i]  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        if (r_mask[i]) begin
          w_idx    = T_WIDTH_RATIO'(i);
          w_oh     = '0;
          w_oh[i]  = 1'b1;
        end
      end
    end
  end

  assign w_any   = |r_mask;
  assign w_one   = w_any && ((r_mask & ~w_oh) == '0);
  assign w_final = !w_any || w_one;
  // Empty, non-last beat carries nothing and is silently released.
  assign w_drop  = r_full && !w_any && !r_last;

  assign m_valid_o = r_full && (w_any || r_last);
  assign m_data_o  = w_any ? r_data[w_idx] : '0;
  assign m_last_o  = r_full && r_last && w_final;

  assign w_pop  = m_valid_o && m_ready_i;
  assign w_done = w_drop || (w_pop && w_final);

  assign s_ready_o = !r_full || w_drop
                   || (m_ready_i && m_valid_o && w_final);
  assign w_load    = s_valid_i && s_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        r_data[i] <= '0;
      end
      r_mask <= '0;
      r_last <= 1'b0;
      r_full <= 1'b0;
    end else if (w_load) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        r_data[i] <= s_data_i[i];
      end
      r_mask <= s_keep_i;
      r_last <= s_last_i;
      r_full <= 1'b1;
    end else if (w_done) begin
      r_mask <= '0;
      r_last <= 1'b0;
      r_full <= 1'b0;
    end else if (w_pop) begin
      r_mask <= r_mask & ~w_oh;
    end
  end

endmodule

// File: tb/tb_stream_downsize_keep.sv
// Directed bench for stream_downsize_keep (8-bit lanes, ratio 4).
// dut0 emits lane 0 first, dut1 emits lane 3 first; both share stimulus.
module tb_stream_downsize_keep;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } rec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data [3:0];
  logic [3:0] s_keep;
  logic       s_last;
  logic       s_valid;
  logic       m_ready;

  logic       s_ready0, m_last0, m_valid0;
  logic [7:0] m_data0;
  logic       s_ready1, m_last1, m_valid1;
  logic [7:0] m_data1;

  int checks;
  int failures;
  int cyc;
  rec_t q0[$];
  rec_t q1[$];

  stream_downsize_keep #(
    .T_DATA_WIDTH(8), .T_DATA_RATIO(4), .T_LANE_ORDER(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready0),
    .m_data_o(m_data0), .m_last_o(m_last0),
    .m_valid_o(m_valid0), .m_ready_i(m_ready)
  );

  stream_downsize_keep #(
    .T_DATA_WIDTH(8), .T_DATA_RATIO(4), .T_LANE_ORDER(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_data_i(s_data), .s_keep_i(s_keep), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready1),
    .m_data_o(m_data1), .m_last_o(m_last1),
    .m_valid_o(m_valid1), .m_ready_i(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (m_valid0 && m_ready) begin
      r.d = m_data0; r.l = m_last0; r.c = cyc;
      q0.push_back(r);
    end
    if (m_valid1 && m_ready) begin
      r.d = m_data1; r.l = m_last1; r.c = cyc;
      q1.push_back(r);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d3, input logic [7:0] d2,
                       input logic [7:0] d1, input logic [7:0] d0,
                       input logic [3:0] k, input logic l,
                       output int t);
    @(posedge clk); #1;
    s_data[3] = d3; s_data[2] = d2;
    s_data[1] = d1; s_data[0] = d0;
    s_keep = k; s_last = l; s_valid = 1'b1;
    t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready0) begin
        t = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (t < 0) begin
      failures++;
      $display("FAIL accept_timeout: got no s_ready want s_ready=1");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    s_keep = 4'hF; s_last = 1'b1;
    for (int i = 0; i < 4; i++) s_data[i] = 8'hA0;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %b/%b want 0/0",
               m_valid0, m_valid1);
    end
    checks++;
    if (m_last0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_last: got %b want 0", m_last0);
    end
    checks++;
    if (m_data0 !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h want 00", m_data0);
    end
    checks++;
    if (s_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", s_ready0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; m_ready = 1'b0;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_keep;
    int t;
    logic [7:0] e [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    m_ready = 1'b1;
    q0.delete();
    drive(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111, 1'b1, t);
    idle(6);
    checks++;
    if (q0.size() != 4) begin
      failures++;
      $display("FAIL full_keep_count: got %0d want 4", q0.size());
    end
    for (int i = 0; i < q0.size() && i < 4; i++) begin
      checks++;
      if (q0[i].d !== e[i] || q0[i].l !== (i == 3) ||
          q0[i].c != t + 1 + i) begin
        failures++;
        $display("FAIL full_keep_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                 i, q0[i].d, q0[i].l, q0[i].c, e[i], (i == 3), t + 1 + i);
      end
    end
  endtask

  task automatic test_sparse;
    int t;
    m_ready = 1'b1;
    q0.delete(); q1.delete();
    drive(8'h44, 8'h33, 8'h22, 8'h11, 4'b1010, 1'b1, t);
    idle(5);
    checks++;
    if (q0.size() != 2 || q1.size() != 2) begin
      failures++;
      $display("FAIL sparse_count: got %0d/%0d want 2/2",
               q0.size(), q1.size());
    end
    if (q0.size() == 2) begin
      checks++;
      if (q0[0].d !== 8'h22 || q0[0].l !== 1'b0) begin
        failures++;
        $display("FAIL sparse_lo0: got d=%h l=%b want d=22 l=0",
                 q0[0].d, q0[0].l);
      end
      checks++;
      if (q0[1].d !== 8'h44 || q0[1].l !== 1'b1) begin
        failures++;
        $display("FAIL sparse_lo1: got d=%h l=%b want d=44 l=1",
                 q0[1].d, q0[1].l);
      end
    end
    if (q1.size() == 2) begin
      checks++;
      if (q1[0].d !== 8'h44 || q1[0].l !== 1'b0) begin
        failures++;
        $display("FAIL sparse_hi0: got d=%h l=%b want d=44 l=0",
                 q1[0].d, q1[0].l);
      end
      checks++;
      if (q1[1].d !== 8'h22 || q1[1].l !== 1'b1) begin
        failures++;
        $display("FAIL sparse_hi1: got d=%h l=%b want d=22 l=1",
                 q1[1].d, q1[1].l);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lows;
    int found;
    logic [7:0] e [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                          8'h55, 8'h66, 8'h77, 8'h88};
    m_ready = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    s_data[0] = 8'h11; s_data[1] = 8'h22;
    s_data[2] = 8'h33; s_data[3] = 8'h44;
    s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_ready: got %b want 1", s_ready0);
    end
    @(posedge clk); #1;
    s_data[0] = 8'h55; s_data[1] = 8'h66;
    s_data[2] = 8'h77; s_data[3] = 8'h88;
    lows = 0; found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (s_ready0) begin
        found = 1;
        break;
      end
      lows++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    idle(6);
    checks++;
    if (found != 1 || lows != 3) begin
      failures++;
      $display("FAIL b2b_ready_pulse: got found=%0d lows=%0d want found=1 lows=3",
               found, lows);
    end
    checks++;
    if (q0.size() != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d want 8", q0.size());
    end
    for (int i = 0; i < q0.size() && i < 8; i++) begin
      checks++;
      if (q0[i].d !== e[i] || q0[i].l !== (i == 3 || i == 7) ||
          q0[i].c != q0[0].c + i) begin
        failures++;
        $display("FAIL b2b_beat%0d: got d=%h l=%b c=%0d want d=%h l=%b c=%0d",
                 i, q0[i].d, q0[i].l, q0[i].c, e[i],
                 (i == 3 || i == 7), q0[0].c + i);
      end
    end
  endtask

  task automatic test_zero_keep;
    int t;
    m_ready = 1'b1;
    q0.delete(); q1.delete();
    drive(8'hDE, 8'hAD, 8'hBE, 8'hEF, 4'b0000, 1'b0, t);
    idle(5);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL zero_drop: got %0d/%0d beats want 0/0",
               q0.size(), q1.size());
    end
    checks++;
    if (s_ready0 !== 1'b1 || m_valid0 !== 1'b0) begin
      failures++;
      $display("FAIL zero_drop_free: got rdy=%b vld=%b want rdy=1 vld=0",
               s_ready0, m_valid0);
    end
    drive(8'hDE, 8'hAD, 8'hBE, 8'hEF, 4'b0000, 1'b1, t);
    idle(4);
    checks++;
    if (q0.size() != 1) begin
      failures++;
      $display("FAIL zero_last_count: got %0d want 1", q0.size());
    end
    if (q0.size() == 1) begin
      checks++;
      if (q0[0].d !== 8'h00 || q0[0].l !== 1'b1 || q0[0].c != t + 1) begin
        failures++;
        $display("FAIL zero_last_beat: got d=%h l=%b c=%0d want d=00 l=1 c=%0d",
                 q0[0].d, q0[0].l, q0[0].c, t + 1);
      end
    end
  endtask

  task automatic test_stall;
    int t;
    logic       pstall;
    logic [7:0] pdata;
    logic       plast;
    logic [7:0] e [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    q0.delete();
    m_ready = 1'b0;
    pstall = 1'b0; pdata = '0; plast = 1'b0;
    fork
      drive(8'h44, 8'h33, 8'h22, 8'h11, 4'b1111, 1'b1, t);
      begin
        for (int n = 0; n < 60; n++) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (pstall) begin
            checks++;
            if (m_valid0 !== 1'b1 || m_data0 !== pdata ||
                m_last0 !== plast) begin
              failures++;
              $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                       m_valid0, m_data0, m_last0, pdata, plast);
            end
          end
          pstall = m_valid0 && !m_ready;
          pdata = m_data0;
          plast = m_last0;
        end
      end
    join
    m_ready = 1'b1;
    idle(8);
    checks++;
    if (q0.size() != 4) begin
      failures++;
      $display("FAIL stall_count: got %0d want 4", q0.size());
    end
    for (int i = 0; i < q0.size() && i < 4; i++) begin
      checks++;
      if (q0[i].d !== e[i] || q0[i].l !== (i == 3)) begin
        failures++;
        $display("FAIL stall_beat%0d: got d=%h l=%b want d=%h l=%b",
                 i, q0[i].d, q0[i].l, e[i], (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid;
    int tr;
    m_ready = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    s_data[0] = 8'h11; s_data[1] = 8'h22;
    s_data[2] = 8'h33; s_data[3] = 8'h44;
    s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (m_valid0 !== 1'b0 || s_ready0 !== 1'b1 || m_last0 !== 1'b0 ||
        m_data0 !== 8'h00) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b r=%b l=%b d=%h want v=0 r=1 l=0 d=00",
               m_valid0, s_ready0, m_last0, m_data0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_data[0] = 8'h99; s_keep = 4'b0001; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    tr = cyc;
    checks++;
    if (s_ready0 !== 1'b1) begin
      failures++;
      $display("FAIL release_ready: got %b want 1", s_ready0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    idle(5);
    checks++;
    if (q0.size() != 3) begin
      failures++;
      $display("FAIL midreset_count: got %0d want 3", q0.size());
    end
    if (q0.size() == 3) begin
      checks++;
      if (q0[0].d !== 8'h11 || q0[1].d !== 8'h22) begin
        failures++;
        $display("FAIL midreset_pre: got %h,%h want 11,22",
                 q0[0].d, q0[1].d);
      end
      checks++;
      if (q0[2].d !== 8'h99 || q0[2].l !== 1'b1 || q0[2].c != tr + 1) begin
        failures++;
        $display("FAIL midreset_post: got d=%h l=%b c=%0d want d=99 l=1 c=%0d",
                 q0[2].d, q0[2].l, q0[2].c, tr + 1);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_keep = '0;
    s_last = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) s_data[i] = '0;
    test_reset;
    test_full_keep;
    test_sparse;
    test_back_to_back;
    test_zero_keep;
    test_stall;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
